// File: rtl/ee357_ctrl_pkg.sv
// rtl/ee357_ctrl_pkg.sv - shared states, opcodes and mux encodings for the EE357 multicycle control
package ee357_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC     = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUSRCB_B       = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // S_DECODE dispatch target; unsupported opcodes fall back to S_FETCH.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: dispatch = S_MEMADR;
      OP_RTYPE:     dispatch = S_EXEC;
      OP_BEQ:       dispatch = S_BEQ;
      OP_J:         dispatch = S_JUMP;
      OP_ADDI:      dispatch = S_ADDI_EX;
      default:      dispatch = S_FETCH;
    endcase
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    op_supported = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                   (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ee357_ctrl_outdec.sv
// rtl/ee357_ctrl_outdec.sv - combinational state-to-control decode (Moore part of the outputs)
module ee357_ctrl_outdec
  import ee357_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // pc_write/ir_write are raw here; the top gates them with mem_ready.
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
        ctrl.ir_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ee357_multicycle_ctrl.sv
// rtl/ee357_multicycle_ctrl.sv - main control FSM for the EE357 multicycle MIPS datapath
module ee357_multicycle_ctrl
  import ee357_ctrl_pkg::*;
#(
  parameter int RESET_STATE_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  localparam logic [1:0] HOLD_CYCLES = 2'(RESET_STATE_HOLD);

  state_t     state;
  state_t     state_n;
  logic [1:0] hold_cnt;
  ctrl_t      ctrl;
  logic       fetch_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 2'd0;
    end else if (state == S_RESET && hold_cnt != HOLD_CYCLES) begin
      hold_cnt <= hold_cnt + 2'd1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RESET:    state_n = (hold_cnt == HOLD_CYCLES) ? S_FETCH : S_RESET;
      S_FETCH:    state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_n = dispatch(opcode);
      S_MEMADR:   state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_n = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWR:    state_n = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:     state_n = S_RTYPE_WB;
      S_RTYPE_WB: state_n = S_FETCH;
      S_BEQ:      state_n = S_FETCH;
      S_JUMP:     state_n = S_FETCH;
      S_ADDI_EX:  state_n = S_ADDI_WB;
      S_ADDI_WB:  state_n = S_FETCH;
      default:    state_n = S_RESET;
    endcase
  end

  ee357_ctrl_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Only the fetch-cycle PC/IR loads wait on memory; jump's pc_write is unconditional.
  assign fetch_done = (state != S_FETCH) || mem_ready;

  assign pc_write      = ctrl.pc_write & fetch_done;
  assign ir_write      = ctrl.ir_write & fetch_done;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = (state == S_DECODE) && !op_supported(opcode);

endmodule

// File: tb/tb_ee357_multicycle_ctrl.sv
// tb/tb_ee357_multicycle_ctrl.sv - directed-vector bench for ee357_multicycle_ctrl
module tb_ee357_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int vectors = 0;
  int miscompares = 0;

  ee357_multicycle_ctrl #(.RESET_STATE_HOLD(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb[2], aop[2], psrc[2], ill}
  function automatic logic [16:0] v(input logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, aop, psrc, input logic ill);
    v = {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  localparam logic [16:0] E_ZERO   = 17'd0;
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  function automatic logic [16:0] observed();
    observed = v(pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op);
  endfunction

  task automatic check_vec(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive mem_ready at the falling edge, sample 1 ns later.
  task automatic step(input string tag, input logic rdy, input logic [16:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    check_vec(tag, observed(), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h23;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_vec("reset_outputs", observed(), E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_vec("reset_state_after_release", observed(), E_ZERO);

    // lw, zero wait states
    step("lw_fetch", 1'b1, E_FETCH);
    step("lw_decode", 1'b1, E_DECODE);
    step("lw_memadr", 1'b1, E_MEMADR);
    step("lw_memrd", 1'b1, E_MEMRD);
    step("lw_memwb", 1'b1, E_MEMWB);

    // R-type with three fetch wait cycles
    opcode = 6'h00;
    step("r_fwait0", 1'b0, E_FWAIT);
    step("r_fwait1", 1'b0, E_FWAIT);
    step("r_fwait2", 1'b0, E_FWAIT);
    step("r_fetch", 1'b1, E_FETCH);
    step("r_decode", 1'b0, E_DECODE);
    step("r_exec", 1'b0, E_EXEC);
    step("r_wb", 1'b1, E_RWB);

    // sw with two MEMWR wait cycles
    opcode = 6'h2B;
    step("sw_fetch", 1'b1, E_FETCH);
    step("sw_decode", 1'b1, E_DECODE);
    step("sw_memadr", 1'b0, E_MEMADR);
    step("sw_memwr0", 1'b0, E_MEMWR);
    step("sw_memwr1", 1'b0, E_MEMWR);
    step("sw_memwr2", 1'b1, E_MEMWR);

    opcode = 6'h04;
    step("beq_fetch", 1'b1, E_FETCH);
    step("beq_decode", 1'b1, E_DECODE);
    step("beq_exec", 1'b0, E_BEQ);

    opcode = 6'h02;
    step("j_fetch", 1'b1, E_FETCH);
    step("j_decode", 1'b1, E_DECODE);
    step("j_jump", 1'b0, E_JUMP);

    opcode = 6'h08;
    step("addi_fetch", 1'b1, E_FETCH);
    step("addi_decode", 1'b1, E_DECODE);
    step("addi_ex", 1'b1, E_ADDIEX);
    step("addi_wb", 1'b0, E_ADDIWB);

    opcode = 6'h3F;
    step("ill_fetch", 1'b1, E_FETCH);
    step("ill_decode", 1'b1, E_DECILL);
    step("ill_next_fetch", 1'b1, E_FETCH);

    // lw aborted by reset while waiting in MEMRD
    opcode = 6'h23;
    step("abort_decode", 1'b1, E_DECODE);
    step("abort_memadr", 1'b1, E_MEMADR);
    step("abort_memrd", 1'b0, E_MEMRD);
    #1 rst_n = 1'b0;
    #1 check_vec("abort_async_zero", observed(), E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1 check_vec("abort_restart_reset", observed(), E_ZERO);
    step("abort_restart_fetch", 1'b1, E_FETCH);
    step("abort_restart_decode", 1'b1, E_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
